multibyte_add_ctrl: RTL and testbench
=====================================

# multibyte_add_ctrl

Sequencer that performs NBYTES-wide additions by running them byte by byte through the team's 8-bit ripple-carry adder, chaining the carry between bytes. It sits around the adder: it feeds operand bytes and carry-in to the adder, then consumes the adder's sum and carry-out. Each operation uses one cycle per byte, so wide additions reuse a single 8-bit datapath.

## Interface
- NBYTES, default 4: number of byte slices per operation; legal range 1..16.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- a_in  in  8*NBYTES  operand A, captured on the accepted start.
- b_in  in  8*NBYTES  operand B, captured on the accepted start.
- cin_in  in  1  carry-in to byte 0, captured on the accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when result, cout_out and ovf are updated.
- result  out  8*NBYTES  sum of the last completed operation.
- cout_out  out  1  carry out of the most significant byte.
- ovf  out  1  two's-complement overflow of the full-width sum.
- add_x  out  8  to adder x.
- add_y  out  8  to adder y.
- add_cin  out  1  to adder cin.
- add_sum  in  8  from adder sum.
- add_cout  in  1  from adder cout.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If start=1 at a clock edge: latch a_in, b_in and cin_in into a_reg, b_reg and carry_reg.
  - On the same edge: set idx=0, clear the working sum register, go to RUN.
  - If start=0: stay in IDLE.
- **RUN, combinational drive to the adder**
  - add_x = a_reg[8*idx +: 8].
  - add_y = b_reg[8*idx +: 8].
  - add_cin = carry_reg.
- **RUN, at each clock edge**
  - Write add_sum into work[8*idx +: 8].
  - Load add_cout into carry_reg.
  - If idx==NBYTES-1, go to DONE; otherwise increment idx.
- **RUN to DONE transition edge**
  - Copy work, with the final byte merged in, to result.
  - Copy the final add_cout to cout_out.
  - Set ovf = (a_reg MSB == b_reg MSB) && (final add_sum[7] != a_reg MSB).
  - Assert done on this edge.
- **DONE**
  - Lasts exactly one cycle with done=1, then returns to IDLE. done drops on that edge.
- **Adder drive outside RUN:** add_x, add_y and add_cin are all 0 in IDLE and DONE.
- **Output holding:** result, cout_out and ovf hold their value until the next completion. Partial sums are never visible on result.
- **Arithmetic:** addition is modulo 2^(8*NBYTES). cout_out is the true carry out, and cin_in participates only at byte 0.
- **start while busy:** ignored, with no queueing. start during the DONE cycle is also ignored.
- **a_in/b_in/cin_in changes after acceptance:** no effect on the operation in flight.
- **NBYTES=1:** RUN lasts a single cycle.

## Timing
- **Reset** (asynchronous, while rst=1):
  - state=IDLE, idx=0.
  - busy=0, done=0, result=0, cout_out=0, ovf=0.
  - add_x=0, add_y=0, add_cin=0.
  - a_reg, b_reg, carry_reg and work are all 0.
- **Reset mid-operation:** aborts immediately to the values above. No done pulse is issued and the prior result is lost (reads 0).
- **Latency**
  - start accepted at edge E. RUN occupies the cycles after edges E .. E+NBYTES-1.
  - done=1 and the new result appear after edge E+NBYTES.
  - Back in IDLE after edge E+NBYTES+1.
  - Earliest next accept is edge E+NBYTES+2, giving a throughput of one operation per NBYTES+2 cycles.
- **busy:** rises after edge E and falls after edge E+NBYTES+1.
- **Adder timing:** the adder path is combinational within a single cycle. add_sum and add_cout must settle within one clk period of add_x, add_y and add_cin.

## Test plan
- **Reset:** assert rst mid-RUN with NBYTES=4 -> all outputs 0 immediately; no done pulse follows after rst is released.
- **Carry chain across all bytes:** a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 RUN cycles done pulses for one cycle; result=0x00000000, cout_out=1, ovf=0; busy high for exactly 5 cycles.
- **Signed overflow:** a=0x7FFFFFFF, b=0x00000001, cin=0 -> result=0x80000000, cout_out=0, ovf=1.
- **Carry-in and negative overflow:** a=0x80000000, b=0x80000000, cin=1 -> result=0x00000001, cout_out=1, ovf=1.
- **Ignored start and operand isolation:**
  - Stimulus: pulse start again during RUN and during DONE, and change a_in/b_in mid-RUN.
  - Required: the first operation completes with its captured operands; exactly one done pulse; no second operation starts.
  - Then a start in IDLE with a=0x12345678, b=0x11111111 -> result=0x23456789 after NBYTES+1 edges.
- **Back-to-back, NBYTES=1:** hold start high continuously with a=0xF0, b=0x20 -> a done pulse every 3 cycles; result=0x10, cout_out=1, ovf=0.

Source files
------------

// File: rtl/multibyte_add_ctrl_if.sv
// Bundle of the request/result handshake and the external 8-bit adder hookup
// for multibyte_add_ctrl.
interface multibyte_add_ctrl_if #(parameter int NBYTES = 4);
    logic                  start;
    logic [8*NBYTES-1:0]   a_in;
    logic [8*NBYTES-1:0]   b_in;
    logic                  cin_in;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   result;
    logic                  cout_out;
    logic                  ovf;
    logic [7:0]            add_x;
    logic [7:0]            add_y;
    logic                  add_cin;
    logic [7:0]            add_sum;
    logic                  add_cout;

    // Requester side; it also hosts the combinational adder.
    modport master (
        output start, a_in, b_in, cin_in, add_sum, add_cout,
        input  busy, done, result, cout_out, ovf, add_x, add_y, add_cin
    );

    modport slave (
        input  start, a_in, b_in, cin_in, add_sum, add_cout,
        output busy, done, result, cout_out, ovf, add_x, add_y, add_cin
    );
endinterface

// File: rtl/multibyte_add_ctrl.sv
// Runs an NBYTES-wide add one byte per cycle through an external 8-bit adder,
// chaining carry between bytes; result/flags update only on completion.
module multibyte_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multibyte_add_ctrl_if.slave    bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q, b_q, work_q, result_q;
    logic            carry_q, busy_q, done_q, cout_q, ovf_q;
    logic [W-1:0]    merged_d;
    logic            last_d;

    // merged_d carries the current byte so the final edge can publish the
    // complete sum without a separate writeback cycle.
    always_comb begin
        merged_d                 = work_q;
        merged_d[8*idx_q +: 8]   = bus.add_sum;
        last_d                   = (idx_q == IW'(NBYTES - 1));
        bus.add_x                = '0;
        bus.add_y                = '0;
        bus.add_cin              = 1'b0;
        if (state_q == RUN) begin
            bus.add_x   = a_q[8*idx_q +: 8];
            bus.add_y   = b_q[8*idx_q +: 8];
            bus.add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        carry_q <= bus.cin_in;
                        idx_q   <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q  <= merged_d;
                    carry_q <= bus.add_cout;
                    if (last_d) begin
                        result_q <= merged_d;
                        cout_q   <= bus.add_cout;
                        ovf_q    <= (a_q[W-1] == b_q[W-1]) && (bus.add_sum[7] != a_q[W-1]);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout_out = cout_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed bench: a 4-byte instance for latency/flags/reset/isolation and a
// 1-byte instance for back-to-back throughput; the bench supplies the adder.
module tb_multibyte_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    multibyte_add_ctrl_if #(.NBYTES(4)) b4 ();
    multibyte_add_ctrl_if #(.NBYTES(1)) b1 ();

    multibyte_add_ctrl #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    multibyte_add_ctrl #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    // The 8-bit ripple-carry adder the sequencer drives.
    assign {b4.add_cout, b4.add_sum} = {1'b0, b4.add_x} + {1'b0, b4.add_y} + {8'd0, b4.add_cin};
    assign {b1.add_cout, b1.add_sum} = {1'b0, b1.add_x} + {1'b0, b1.add_y} + {8'd0, b1.add_cin};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, then follow it until busy drops; checks latency and flags.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] er, input logic ec, input logic eo);
        int nbusy = 0, ndone = 0, done_at = -1, k = 0;
        b4.a_in = a; b4.b_in = b; b4.cin_in = cin; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        while (b4.busy && k < 20) begin
            nbusy++;
            if (b4.done) begin
                ndone++;
                done_at = k;
            end
            tick();
            k++;
        end
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'd5);
        chk({tag, " done_pulses"}, 64'(ndone), 64'd1);
        chk({tag, " done_latency"}, 64'(done_at), 64'd4);
        chk({tag, " result"}, 64'(b4.result), 64'(er));
        chk({tag, " cout"}, 64'(b4.cout_out), 64'(ec));
        chk({tag, " ovf"}, 64'(b4.ovf), 64'(eo));
    endtask

    initial begin
        int ndone, nbusy_after;
        int d_at[$];
        b4.start = 0; b4.a_in = '0; b4.b_in = '0; b4.cin_in = 0;
        b1.start = 0; b1.a_in = '0; b1.b_in = '0; b1.cin_in = 0;
        #12;
        chk("rst busy", 64'(b4.busy), 0);
        chk("rst done", 64'(b4.done), 0);
        chk("rst result", 64'(b4.result), 0);
        chk("rst add_x", 64'(b4.add_x), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        chk("idle add_x", 64'(b4.add_x), 0);
        chk("idle add_cin", 64'(b4.add_cin), 0);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
        repeat (3) tick();
        chk("hold result", 64'(b4.result), 64'h1);

        // Ignored starts during RUN/DONE and operand changes mid-flight.
        b4.a_in = 32'h0102_0304; b4.b_in = 32'h1020_3040; b4.cin_in = 0; b4.start = 1;
        tick();
        b4.start = 0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            b4.start = (k == 1) || b4.done;
            if (k == 1) begin
                b4.a_in = 32'hFFFF_FFFF; b4.b_in = 32'hFFFF_FFFF;
            end
            if (k == 2) chk("run add_x byte2", 64'(b4.add_x), 64'h02);
            if (b4.done) ndone++;
            tick();
        end
        b4.start = 0;
        chk("iso done_pulses", 64'(ndone), 1);
        chk("iso result", 64'(b4.result), 64'h1122_3344);
        chk("iso no_restart", 64'(b4.busy), 0);
        run_op("seq", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Reset mid-RUN.
        b4.a_in = 32'hAAAA_AAAA; b4.b_in = 32'h1111_1111; b4.start = 1;
        tick();
        b4.start = 0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst busy", 64'(b4.busy), 0);
        chk("mid_rst result", 64'(b4.result), 0);
        chk("mid_rst cout", 64'(b4.cout_out), 0);
        chk("mid_rst ovf", 64'(b4.ovf), 0);
        chk("mid_rst add_x", 64'(b4.add_x), 0);
        chk("mid_rst add_y", 64'(b4.add_y), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0; nbusy_after = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (b4.done) ndone++;
            if (b4.busy) nbusy_after++;
        end
        chk("post_rst done", 64'(ndone), 0);
        chk("post_rst busy", 64'(nbusy_after), 0);

        // Back-to-back with NBYTES=1 and start held high.
        b1.a_in = 8'hF0; b1.b_in = 8'h20; b1.cin_in = 0; b1.start = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (b1.done) d_at.push_back(k);
        end
        b1.start = 0;
        chk("b2b done_count", 64'(d_at.size()), 4);
        for (int i = 1; i < d_at.size(); i++)
            chk("b2b period", 64'(d_at[i] - d_at[i-1]), 3);
        chk("b2b result", 64'(b1.result), 64'h10);
        chk("b2b cout", 64'(b1.cout_out), 1);
        chk("b2b ovf", 64'(b1.ovf), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
